// File: rtl/sp_transmitter_if.sv
// Parallel-request / serial-line bundle between a frame source and the SPI-style transmitter.
// The master side requests frames; the slave side is the transmitter that drives the wire.
interface sp_transmitter_if #(
  parameter int DATA_W = 10
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;

  modport master (
    output start, data_in,
    input  sclk, mosi, cs_n, busy, done
  );

  modport slave (
    input  start, data_in,
    output sclk, mosi, cs_n, busy, done
  );
endinterface

// File: rtl/sp_transmitter.sv
// SPI-style (CPOL=0, CPHA=0) frame transmitter: MSB first, programmable SCLK half-period,
// chip-select framing with one half-period of setup and hold around the clock burst.
module sp_transmitter #(
  parameter int DATA_W  = 10,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  sp_transmitter_if.slave  bus
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              sclk_reg;
  logic              cs_n_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              div_last;

  assign div_last = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  // mosi is the MSB of the shift register, so it is registered and changes only when
  // the register is loaded, shifted on the SCLK fall, or cleared at frame end.
  assign bus.mosi = shift_reg[DATA_W-1];
  assign bus.sclk = sclk_reg;
  assign bus.cs_n = cs_n_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sclk_reg <= 1'b0;
          cs_n_reg <= 1'b1;
          if (bus.start) begin
            shift_reg   <= bus.data_in;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            cs_n_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= LEAD;
          end
        end
        LEAD: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b1;
            state_reg   <= HIGH;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
              state_reg <= TRAIL;
            end else begin
              shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              state_reg   <= LOW;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        LOW: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b1;
            state_reg   <= HIGH;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            shift_reg   <= '0;
            cs_n_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_transmitter.sv
// Randomized bench for sp_transmitter: one instance at the default divider, one at CLK_DIV=1,
// each with a sclk-clocked receiver shift register on its serial output.
module tb_sp_transmitter;
  localparam int W   = 10;
  localparam int CDA = 4;
  localparam int CDB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  sp_transmitter_if #(.DATA_W(W)) ifa ();
  sp_transmitter_if #(.DATA_W(W)) ifb ();

  sp_transmitter #(.DATA_W(W), .CLK_DIV(CDA)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  sp_transmitter #(.DATA_W(W), .CLK_DIV(CDB)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] rx_a = '0;
  logic [W-1:0] rx_b = '0;
  always @(posedge ifa.sclk) rx_a <= {rx_a[W-2:0], ifa.mosi};
  always @(posedge ifb.sclk) rx_b <= {rx_b[W-2:0], ifb.mosi};

  int   checks = 0;
  int   errors = 0;
  int   rise_cyc [$];
  logic rise_bit [$];
  int   done_cyc [$];
  int   busy_cnt;
  logic prev_sclk [2];
  logic prev_mosi [2];
  logic prev_cs   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle observation of one transmitter's outputs into the shared event log.
  task automatic mon(input int d, input logic s, input logic m, input logic c,
                     input logic b, input logic dn);
    if (s && !prev_sclk[d]) begin
      rise_cyc.push_back(cyc);
      rise_bit.push_back(m);
      check("cs_at_rise", {31'd0, c}, 32'd0);
    end
    if (m !== prev_mosi[d])
      check("mosi_change", {31'd0, (prev_sclk[d] && !s) || (c !== prev_cs[d])}, 32'd1);
    if (dn) done_cyc.push_back(cyc);
    if (b) busy_cnt++;
    prev_sclk[d] = s;
    prev_mosi[d] = m;
    prev_cs[d]   = c;
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, ifa.sclk, ifa.mosi, ifa.cs_n, ifa.busy, ifa.done);
    mon(1, ifb.sclk, ifb.mosi, ifb.cs_n, ifb.busy, ifb.done);
  endtask

  task automatic clear();
    rise_cyc.delete();
    rise_bit.delete();
    done_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic drive_start(input int d, input logic s, input logic [W-1:0] data);
    if (d == 0) begin ifa.start = s; ifa.data_in = data; end
    else        begin ifb.start = s; ifb.data_in = data; end
  endtask

  task automatic launch(input int d, input logic [W-1:0] data, output int sc);
    drive_start(d, 1'b1, data);
    sc = cyc;
    tick();
    drive_start(d, 1'b0, W'($urandom));
  endtask

  task automatic wait_done(input int n);
    int budget = 400;
    while (done_cyc.size() < n && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  // Expected timeline straight from the frame rules: rise k at 1+cd*(2k+1), done at 1+cd*(2W+1).
  task automatic check_frame(input string tag, input logic [W-1:0] data, input int sc,
                             input int cd, input int ri, input int di);
    for (int k = 0; k < W; k++) begin
      if (ri + k < rise_cyc.size()) begin
        check({tag, "_rise_cyc"}, rise_cyc[ri+k], sc + 1 + cd * (2 * k + 1));
        check({tag, "_bit"}, {31'd0, rise_bit[ri+k]}, {31'd0, data[W-1-k]});
      end
    end
    check({tag, "_done_cyc"}, (di < done_cyc.size()) ? done_cyc[di] : -1,
          sc + 1 + cd * (2 * W + 1));
  endtask

  task automatic run(input string tag, input int d, input logic [W-1:0] data);
    int sc;
    int cd = (d == 0) ? CDA : CDB;
    clear();
    launch(d, data, sc);
    wait_done(1);
    repeat (4) tick();
    check_frame(tag, data, sc, cd, 0, 0);
    check({tag, "_nrise"}, rise_cyc.size(), W);
    check({tag, "_ndone"}, done_cyc.size(), 1);
    check({tag, "_busy"}, busy_cnt, cd * (2 * W + 1));
    check({tag, "_loop"}, {22'd0, (d == 0) ? rx_a : rx_b}, {22'd0, data});
  endtask

  initial begin
    int sc, sc2;
    logic [W-1:0] v;
    prev_sclk = '{1'b0, 1'b0};
    prev_mosi = '{1'b0, 1'b0};
    prev_cs   = '{1'b1, 1'b1};
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.start = 1'b1; ifa.data_in = W'($urandom);
    ifb.start = 1'b1; ifb.data_in = W'($urandom);
    busy_cnt = 0;

    // Reset held with start asserted: reset wins every cycle.
    repeat (3) begin
      tick();
      check("rst_cs_n", {31'd0, ifa.cs_n}, 32'd1);
      check("rst_sclk", {31'd0, ifa.sclk}, 32'd0);
      check("rst_mosi", {31'd0, ifa.mosi}, 32'd0);
      check("rst_busy", {31'd0, ifa.busy}, 32'd0);
      check("rst_done", {31'd0, ifa.done}, 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0;
    clear();
    repeat (20) tick();
    check("idle_busy", busy_cnt, 0);
    check("idle_rise", rise_cyc.size(), 0);

    run("basic", 0, 10'b1011001110);
    run("lb3ff", 0, 10'h3FF);
    run("lb000", 0, 10'h000);
    run("lb155", 0, 10'h155);
    run("lb2aa", 0, 10'h2AA);
    repeat (3) run("rand_a", 0, W'($urandom));

    // start during a frame in flight must be ignored
    clear();
    launch(0, 10'h155, sc);
    while (cyc < sc + 30) tick();
    drive_start(0, 1'b1, 10'h2AA);
    tick();
    drive_start(0, 1'b0, W'($urandom));
    wait_done(1);
    repeat (6) tick();
    check_frame("ign", 10'h155, sc, CDA, 0, 0);
    check("ign_ndone", done_cyc.size(), 1);
    check("ign_loop", {22'd0, rx_a}, 32'h155);

    // back-to-back: start accepted in the done cycle
    clear();
    launch(0, 10'h30F, sc);
    wait_done(1);
    check("b2b_cs_done", {31'd0, ifa.cs_n}, 32'd1);
    drive_start(0, 1'b1, 10'h0F0);
    sc2 = cyc;
    tick();
    drive_start(0, 1'b0, W'($urandom));
    check("b2b_cs_low", {31'd0, ifa.cs_n}, 32'd0);
    wait_done(2);
    repeat (4) tick();
    check_frame("b2b1", 10'h30F, sc, CDA, 0, 0);
    check_frame("b2b2", 10'h0F0, sc2, CDA, W, 1);
    check("b2b_nrise", rise_cyc.size(), 2 * W);
    check("b2b_gap", (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1, 85);
    check("b2b_loop", {22'd0, rx_a}, 32'h0F0);

    // abort with rst mid-frame on the CLK_DIV=1 instance
    clear();
    v = W'($urandom);
    launch(1, v, sc);
    while (cyc < sc + 8) tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("abort_cs_n", {31'd0, ifb.cs_n}, 32'd1);
    check("abort_sclk", {31'd0, ifb.sclk}, 32'd0);
    check("abort_mosi", {31'd0, ifb.mosi}, 32'd0);
    check("abort_busy", {31'd0, ifb.busy}, 32'd0);
    check("abort_done", {31'd0, ifb.done}, 32'd0);
    repeat (30) tick();
    check("abort_ndone", done_cyc.size(), 0);

    run("div1_201", 1, 10'h201);
    repeat (3) run("rand_b", 1, W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_transmitter.md
# sp_transmitter

SPI-style serial transmitter for the FPGA side of the link. It takes a parallel frame (default 10 bits), drives chip-select low, and generates SCLK with a programmable divider. It shifts the frame out MSB first on MOSI, then releases chip-select and pulses `done`. It is the sending end for the team's 10-stage shift-register receiver, which samples MOSI on each SCLK rising edge. After a full frame, the receiver's `data_received` equals this block's `data_in`.

## Interface
- `DATA_W`, 10, frame length in bits (≥2)
- `CLK_DIV`, 4, SCLK half-period in `clk` cycles (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request to send; accepted only when `busy`=0
- `data_in`  in  DATA_W  frame to send; sampled only on the accepted `start` cycle
- `sclk`  out  1  serial clock, idle low (CPOL=0, CPHA=0)
- `mosi`  out  1  serial data, MSB first
- `cs_n`  out  1  active-low chip select
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame end

## Operation
- All outputs are registered. Reset values: `sclk`=0, `mosi`=0, `cs_n`=1, `busy`=0, `done`=0, state IDLE, counters 0.
- State machine: IDLE → LEAD → HIGH ⇄ LOW → TRAIL → IDLE.
- IDLE:
  - Outputs `sclk`=0 and `cs_n`=1.
  - On `start`=1: load the shift register with `data_in`, clear `bit_cnt` and `div_cnt`, go to LEAD.
  - The next cycle shows `cs_n`=0, `busy`=1, `mosi`=`data_in[DATA_W-1]`.
- LEAD: hold `sclk`=0 for CLK_DIV cycles (setup time), then go to HIGH.
- HIGH:
  - Hold `sclk`=1 for CLK_DIV cycles; the receiver samples on the 0→1 edge.
  - At the end, if `bit_cnt`=DATA_W-1 go to TRAIL.
  - Otherwise go to LOW: shift left, increment `bit_cnt`, and present the next bit on `mosi` coincident with `sclk` falling.
- LOW: hold `sclk`=0 for CLK_DIV cycles, then go to HIGH.
- TRAIL:
  - Hold `sclk`=0 and `cs_n`=0 for CLK_DIV cycles (hold time).
  - Then return to IDLE: `cs_n`=1, `busy`=0, `done`=1 for exactly one cycle, `mosi`=0.
- `div_cnt` counts 0..CLK_DIV-1 within each phase and wraps to 0 on every state change. `bit_cnt` width is clog2(DATA_W).
- Boundary conditions:
  - `start` while `busy`=1: ignored. No effect on the frame in flight; `data_in` is not re-sampled.
  - `start` in the `done` cycle: accepted (back-to-back). `cs_n` is high for exactly 1 cycle between frames.
  - `rst` mid-frame: the next cycle has all reset values. The frame is aborted, no `done` pulse, and the partial frame is discarded.
  - `rst` and `start` in the same cycle: reset wins; the frame is not started.
  - Exactly DATA_W rising SCLK edges per frame; no SCLK edge while `cs_n`=1.

## Timing
- The accepted `start` is cycle 0. `cs_n` falls and `busy` rises in cycle 1.
- First `sclk` rise: cycle 1+CLK_DIV.
- Rising edge k (k=0..DATA_W-1): cycle 1+CLK_DIV·(2k+1).
- `mosi` changes only in cycles where `sclk` falls, or at frame start/end. It is stable for ≥CLK_DIV cycles on either side of every rising edge.
- `busy` high for CLK_DIV·(2·DATA_W+1) cycles: 84 cycles for the defaults.
- `done`, `cs_n`↑ and `busy`↓ occur in the same cycle: cycle 1+CLK_DIV·(2·DATA_W+1), which is 85 for the defaults.
- SCLK frequency = f_clk / (2·CLK_DIV).

## Test plan
- Reset values: hold `rst` for 3 cycles with `start`=1 → `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0 throughout; no frame starts after release until a new `start`.
- Basic frame: defaults, `data_in`=10'b1011001110, one-cycle `start` → `mosi` sampled at `sclk` rises reads 1,0,1,1,0,0,1,1,1,0. Exactly 10 rises, first at cycle 5. `busy` high 84 cycles. Single `done` at cycle 85.
- Loopback: `sclk`/`mosi` into a 10-stage receiver shift register clocked by `sclk`; send 10'h3FF, 10'h000, 10'h155, 10'h2AA → receiver word equals `data_in` at each `done`.
- Ignored start: start 10'h155, pulse `start` with `data_in`=10'h2AA at cycle 30 → transmitted bits still 10'h155; only one `done`.
- Back-to-back: assert `start` (10'h0F0) in the `done` cycle of a previous 10'h30F frame → `cs_n` high exactly 1 cycle; both frames correct; two `done` pulses 85 cycles apart.
- Abort and divider: CLK_DIV=1, assert `rst` at cycle 8 mid-frame → idle outputs next cycle, no `done`. A fresh frame of 10'h201 then completes in 21 busy cycles with bits 1,0,0,0,0,0,0,0,0,1.
